// File: rtl/uart_fifo_flex_pkg.sv
// uart_fifo_flex_pkg
// Shared constants and types for the UART FIFO slice.
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF : default word width, address width, depth
//   AE_LEVEL_DEF                        : default almost_empty threshold
//   fifo_status_t                       : status-flag bundle, fixed bit ordering
package uart_fifo_flex_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 4;
  localparam int DEPTH_DEF    = 2**ADDR_W_DEF;
  localparam int AE_LEVEL_DEF = 2;

  // MSB..LSB: overflow, underflow, almost_full, almost_empty, full, empty
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic almost_full;
    logic almost_empty;
    logic full;
    logic empty;
  } fifo_status_t;

  // Status value the FIFO presents while held in reset or right after a flush
  function automatic fifo_status_t idle_status();
    fifo_status_t s;
    s = '0;
    s.empty        = 1'b1;
    s.almost_empty = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo_flex_if.sv
// uart_fifo_flex_if
// Push/pop/status bundle between a FIFO user (master) and the FIFO (slave).
//   clr, wr, w_data, rd          : driven by master
//   r_data, count, status flags  : driven by slave
interface uart_fifo_flex_if import uart_fifo_flex_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              clr;
  logic              wr;
  logic [DATA_W-1:0] w_data;
  logic              rd;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr, w_data, rd,
    input  r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  clr, wr, w_data, rd,
    output r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/uart_fifo_flex_ram.sv
// uart_fifo_ram
// FIFO storage: synchronous write, asynchronous (combinational) read, no reset.
//   clk    : write clock
//   we     : write enable
//   w_addr : write address,  w_data : write word
//   r_addr : read address,   r_data : word at r_addr
module uart_fifo_ram import uart_fifo_flex_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_fifo_flex.sv
// uart_fifo_flex
// Show-ahead synchronous FIFO with thresholds and sticky error flags.
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-high reset
//   bus    : slave side of uart_fifo_flex_if (clr/wr/w_data/rd in,
//            r_data/count/empty/full/almost_*/overflow/underflow out)
module uart_fifo_flex import uart_fifo_flex_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = (2**ADDR_W) - 2,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic           clk,
  input  logic           reset,
  uart_fifo_flex_if.slave bus
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow_q;
  logic              underflow_q;
  logic              push_ok;
  logic              pop_ok;
  fifo_status_t      status;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge;
  // rd on a full FIFO is always accepted because full implies non-empty.
  assign pop_ok  = bus.rd && !status.empty;
  assign push_ok = bus.wr && (!status.full || pop_ok);

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we     (push_ok && !bus.clr),
    .w_addr (wr_ptr),
    .w_data (bus.w_data),
    .r_addr (rd_ptr),
    .r_data (bus.r_data)
  );

  // Pointers wrap naturally at ADDR_W bits; clr beats any simultaneous wr/rd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.wr && status.full && !bus.rd) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd && status.empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Occupancy flags decode straight from the registered count so they follow
  // reset asynchronously and can never show empty and full together.
  always_comb begin
    status              = idle_status();
    status.empty        = (count == '0);
    status.full         = (count == DEPTH_CNT);
    status.almost_empty = (count <= AE_CNT);
    status.almost_full  = (count >= AF_CNT);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  assign bus.count        = count;
  assign bus.empty        = status.empty;
  assign bus.full         = status.full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.overflow     = status.overflow;
  assign bus.underflow    = status.underflow;

endmodule

// File: tb/tb_uart_fifo_flex.sv
// tb_uart_fifo_flex
// Directed self-checking bench for uart_fifo_flex at default parameters
// (DATA_W=8, ADDR_W=4, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2).
module tb_uart_fifo_flex;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  uart_fifo_flex_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_fifo_flex dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the stimulus
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, need 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1ns later, then idle the strobes
  task automatic applyStimulus(input logic wr, input logic rd, input logic clr, input logic [7:0] data);
    bus.wr     = wr;
    bus.rd     = rd;
    bus.clr    = clr;
    bus.w_data = data;
    @(posedge clk);
    #1;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_count"}, 32'(bus.count), 32'd0);
    checkOutput({tag, "_empty"}, 32'(bus.empty), 32'd1);
    checkOutput({tag, "_full"},  32'(bus.full),  32'd0);
    checkOutput({tag, "_ae"},    32'(bus.almost_empty), 32'd1);
    checkOutput({tag, "_af"},    32'(bus.almost_full),  32'd0);
    checkOutput({tag, "_ovf"},   32'(bus.overflow),  32'd0);
    checkOutput({tag, "_udf"},   32'(bus.underflow), 32'd0);
  endtask

  initial begin
    logic [7:0] vec3 [3];
    logic [7:0] exp_head;
    compared   = 0;
    mismatched = 0;
    vec3[0] = 8'h11;
    vec3[1] = 8'h22;
    vec3[2] = 8'h33;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0; bus.w_data = '0;

    // Reset state
    reset = 1'b1;
    #12;
    checkIdle("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Push 0x11,0x22,0x33 then pop them back in order
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, vec3[i]);
      checkOutput("push3_count", 32'(bus.count), 32'(i + 1));
      checkOutput("push3_head", 32'(bus.r_data), 32'h11);
      checkOutput("push3_empty", 32'(bus.empty), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("pop3_data", 32'(bus.r_data), 32'(vec3[i]));
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("pop3_count", 32'(bus.count), 32'(2 - i));
    end
    checkOutput("pop3_empty", 32'(bus.empty), 32'd1);
    checkOutput("pop3_udf", 32'(bus.underflow), 32'd0);

    // Fill to 16 checking thresholds, then one push too many
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      checkOutput("fill_count", 32'(bus.count), 32'(i + 1));
      checkOutput("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 14));
      checkOutput("fill_ae", 32'(bus.almost_empty), 32'((i + 1) <= 2));
      checkOutput("fill_full", 32'(bus.full), 32'((i + 1) == 16));
    end
    checkOutput("fill_ovf_before", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);
    checkOutput("over_count", 32'(bus.count), 32'd16);
    checkOutput("over_full", 32'(bus.full), 32'd1);
    checkOutput("over_ovf", 32'(bus.overflow), 32'd1);
    checkOutput("over_head", 32'(bus.r_data), 32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("over_sticky", 32'(bus.overflow), 32'd1);

    // Flush, refill, then stream wr+rd on a full FIFO across the wrap point
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkIdle("clr1");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    end
    checkOutput("refill_count", 32'(bus.count), 32'd16);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
      exp_head = (k < 16) ? 8'(8'h40 + k) : 8'hA5;
      checkOutput("stream_head", 32'(bus.r_data), 32'(exp_head));
      checkOutput("stream_count", 32'(bus.count), 32'd16);
      checkOutput("stream_full", 32'(bus.full), 32'd1);
    end
    checkOutput("stream_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_data", 32'(bus.r_data), 32'hA5);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    end
    checkOutput("drain_count", 32'(bus.count), 32'd0);
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);
    checkOutput("drain_udf", 32'(bus.underflow), 32'd0);

    // wr+rd on an empty FIFO: push lands, pop flagged as underflow
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    checkOutput("er_count", 32'(bus.count), 32'd1);
    checkOutput("er_data", 32'(bus.r_data), 32'h5A);
    checkOutput("er_udf", 32'(bus.underflow), 32'd1);
    checkOutput("er_empty", 32'(bus.empty), 32'd0);
    // clr together with wr: flush wins
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h99);
    checkIdle("clr2");

    // Plain rd on empty
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("rdempty_udf", 32'(bus.underflow), 32'd1);
    checkOutput("rdempty_count", 32'(bus.count), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Reset mid-stream while pushing
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    end
    checkOutput("pre_rst_count", 32'(bus.count), 32'd5);
    bus.wr     = 1'b1;
    bus.w_data = 8'h66;
    #1;
    reset = 1'b1;
    #1;
    checkIdle("midrst");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    bus.wr = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
    checkOutput("post_rst_data", 32'(bus.r_data), 32'h77);
    checkOutput("post_rst_count", 32'(bus.count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_fifo_flex.md
UART_FIFO_FLEX -- requirements
Module: uart_fifo_flex

Interface
REQ-001 Parameter DATA_W, default 8, bits per word.
REQ-002 Parameter ADDR_W, default 4, address bits; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 clr  input  1  synchronous flush, active-high.
REQ-008 wr  input  1  push request.
REQ-009 w_data  input  DATA_W  push word.
REQ-010 rd  input  1  pop request.
REQ-011 r_data  output  DATA_W  head word (show-ahead), valid while empty=0.
REQ-012 empty, full  output  1 each  occupancy status.
REQ-013 almost_empty, almost_full  output  1 each  threshold status.
REQ-014 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Push accepted when wr=1 and (full=0 or rd accepted same cycle); word stored at write pointer on the edge.
REQ-017 Pop accepted when rd=1 and empty=0; read pointer advances on the edge; r_data shows next head combinationally, zero-cycle read latency.
REQ-018 Write-to-read latency: word written at edge N is visible on r_data and empty=0 after edge N.
REQ-019 Pointers wrap DEPTH-1 -> 0 modulo 2**ADDR_W.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-021 empty = (count==0), full = (count==DEPTH), both registered or derived from registered count; never both 1.
REQ-022 wr&rd while empty: push performed, pop ignored, underflow set, count becomes 1.
REQ-023 wr&rd while full: both performed, count stays DEPTH, full stays 1, no overflow.
REQ-024 wr while full without rd: ignored, memory and pointers unchanged, overflow set.
REQ-025 rd while empty without wr: ignored, underflow set.
REQ-026 overflow/underflow stay 1 until reset or clr.
REQ-027 clr: pointers and count to 0, empty=1, flags cleared on that edge; clr has priority over simultaneous wr/rd, which are discarded.
REQ-028 Memory contents not cleared by reset or clr; r_data undefined while empty.

Reset
REQ-029 reset asserted: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, immediately and asynchronously.
REQ-030 reset mid-operation discards all stored words; first push after release behaves as into an empty FIFO.

Structure
REQ-031 Default widths and depth constants, and the status-flag bundle ordering, SHALL live in the shared UART package.
REQ-032 Storage SHALL be one sub-module, uart_fifo_ram: synchronous write, asynchronous read, no reset.
REQ-033 Control (pointers, count, flags) SHALL be in uart_fifo_flex; no additional sub-modules.

Verification
REQ-034 Reset, push 0x11,0x22,0x33, then pop 3 -> r_data 0x11,0x22,0x33 in order, count 3->0, empty=1 at end.
REQ-035 DEPTH=16: push 16 words -> full=1, count=16, almost_full from count 14; 17th push -> ignored, overflow=1.
REQ-036 Full FIFO, wr=rd=1 with 0xA5 for 20 cycles -> count stays 16, wrap exercised, data order preserved, overflow=0.
REQ-037 Empty FIFO, wr=rd=1 with 0x5A -> count=1, r_data=0x5A, underflow=1; then clr -> count=0, flags 0, empty=1.
REQ-038 Push 5 words, assert reset mid-stream with wr=1 -> all outputs at reset values immediately; after release push 0x77 -> r_data=0x77, count=1.
